// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 2R1W register file: round-robin sharing of the
// single write port between NREQ requesters, plus a command-driven zero-fill.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | arbitrate requesters onto the write port, accept clr_start
// S_CLEAR | write zero to one entry per cycle, index 0..DEPTH-1
module regfile_wr_sched #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    parameter  int NREQ  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int GW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_write_reg,
    output logic [WIDTH-1:0]      rf_write_data,
    output logic [GW-1:0]         grant_id
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
    localparam logic [GW-1:0] REQ_LAST = GW'(NREQ - 1);

    state_t           state_q, state_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             we_d, done_d;
    logic [AW-1:0]    wreg_d;
    logic [WIDTH-1:0] wdata_d;
    logic [GW-1:0]    gid_d;

    logic [AW-1:0]    addr_arr [NREQ];
    logic [WIDTH-1:0] data_arr [NREQ];
    logic [NREQ-1:0]  sel_oh;
    logic [GW-1:0]    sel_idx;
    logic             sel_vld;
    logic             clr_last;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*AW +: AW];
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // First valid requester at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        int            cand;
        logic [GW-1:0] cand_idx;
        sel_oh  = '0;
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = GW'(cand);
            if (!sel_vld && req_valid[cand_idx]) begin
                sel_vld          = 1'b1;
                sel_idx          = cand_idx;
                sel_oh[cand_idx] = 1'b1;
            end
        end
    end

    assign clr_last = (state_q == S_CLEAR) && (clr_cnt_q == CLR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clr_start) state_d = S_CLEAR;
            S_CLEAR: if (clr_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        clr_busy  = (state_q == S_CLEAR);
        we_d      = 1'b0;
        done_d    = 1'b0;
        wreg_d    = rf_write_reg;
        wdata_d   = rf_write_data;
        gid_d     = grant_id;
        rr_ptr_d  = rr_ptr_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    // Entry 0 is presented in the first CLEAR cycle.
                    we_d      = 1'b1;
                    wreg_d    = '0;
                    wdata_d   = '0;
                    clr_cnt_d = '0;
                end else begin
                    req_ready = sel_oh;
                    if (sel_vld) begin
                        we_d     = 1'b1;
                        wreg_d   = addr_arr[sel_idx];
                        wdata_d  = data_arr[sel_idx];
                        gid_d    = sel_idx;
                        rr_ptr_d = (sel_idx == REQ_LAST) ? '0 : sel_idx + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_last) begin
                    clr_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    we_d      = 1'b1;
                    wreg_d    = clr_cnt_q + 1'b1;
                    wdata_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            clr_cnt_q     <= '0;
            rf_we         <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            grant_id      <= '0;
            clr_done      <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            clr_cnt_q     <= clr_cnt_d;
            rf_we         <= we_d;
            rf_write_reg  <= wreg_d;
            rf_write_data <= wdata_d;
            grant_id      <= gid_d;
            clr_done      <= done_d;
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched with a behavioural register file on the
// write port; inputs change and outputs are sampled around the falling edge.
module tb_regfile_wr_sched;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int NREQ  = 4;
    localparam int AW    = 3;
    localparam int GW    = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  clr_start;
    logic                  clr_busy;
    logic                  clr_done;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rf_we;
    logic [AW-1:0]         rf_write_reg;
    logic [WIDTH-1:0]      rf_write_data;
    logic [GW-1:0]         grant_id;

    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    regfile_wr_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_start     (clr_start),
        .clr_busy      (clr_busy),
        .clr_done      (clr_done),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_we         (rf_we),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we) mem[rf_write_reg] <= rf_write_data;

    task automatic test_reset();
        rst_n = 1'b0; clr_start = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        #12;
        checks++;
        if ({rf_we, clr_busy, clr_done} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got we/busy/done=%b want 000", {rf_we, clr_busy, clr_done});
        end
        checks++;
        if ({rf_write_reg, rf_write_data, grant_id} !== '0) begin
            errors++; $display("FAIL reset_data got reg=%0d data=%h gid=%0d want 0", rf_write_reg, rf_write_data, grant_id);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_clear();
        clr_start = 1'b1;
        @(negedge clk) clr_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if ({rf_we, clr_busy, clr_done, rf_write_reg, rf_write_data} !== {3'b110, 3'(i), 16'h0000}) begin
                errors++; $display("FAIL clear_step%0d got we=%b busy=%b done=%b reg=%0d data=%h want 1 1 0 %0d 0000",
                                   i, rf_we, clr_busy, clr_done, rf_write_reg, rf_write_data, i);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({rf_we, clr_busy, clr_done} !== 3'b001) begin
            errors++; $display("FAIL clear_done got we/busy/done=%b want 001", {rf_we, clr_busy, clr_done});
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (mem[i] !== 16'h0000) begin
                errors++; $display("FAIL clear_mem%0d got %h want 0000", i, mem[i]);
            end
        end
        @(negedge clk) #1;
        checks++;
        if (clr_done !== 1'b0) begin
            errors++; $display("FAIL clear_done_pulse got %b want 0", clr_done);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100; req_addr[2*AW +: AW] = 3'd5; req_data[2*WIDTH +: WIDTH] = 16'hBEEF;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready got %b want 0100", req_ready);
        end
        @(negedge clk) req_valid = '0;
        #1;
        checks++;
        if ({rf_we, rf_write_reg, grant_id, rf_write_data} !== {1'b1, 3'd5, 2'd2, 16'hBEEF}) begin
            errors++; $display("FAIL single_grant got we=%b reg=%0d gid=%0d data=%h want 1 5 2 beef",
                               rf_we, rf_write_reg, grant_id, rf_write_data);
        end
        checks++;
        if (mem[5] !== 16'h0000) begin
            errors++; $display("FAIL single_old_read got %h want 0000", mem[5]);
        end
        @(negedge clk) #1;
        checks++;
        if (mem[5] !== 16'hBEEF) begin
            errors++; $display("FAIL single_commit got %h want beef", mem[5]);
        end
        checks++;
        if ({rf_we, rf_write_reg, grant_id} !== {1'b0, 3'd5, 2'd2}) begin
            errors++; $display("FAIL single_hold got we=%b reg=%0d gid=%0d want 0 5 2", rf_we, rf_write_reg, grant_id);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]       = 3'(i);
            req_data[i*WIDTH +: WIDTH] = 16'hA000 + 16'(i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++; $display("FAIL rr_ready%0d got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                checks++;
                if ({rf_we, grant_id} !== {1'b1, 2'((k - 1) % 4)}) begin
                    errors++; $display("FAIL rr_grant%0d got we=%b gid=%0d want 1 %0d", k, rf_we, grant_id, (k - 1) % 4);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        checks++;
        if ({rf_we, grant_id, rf_write_data} !== {1'b1, 2'd3, 16'hA003}) begin
            errors++; $display("FAIL rr_last got we=%b gid=%0d data=%h want 1 3 a003", rf_we, grant_id, rf_write_data);
        end
        @(negedge clk) #1;
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (mem[i] !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL rr_mem%0d got %h want %h", i, mem[i], 16'hA000 + 16'(i));
            end
        end
    endtask

    task automatic test_clr_priority();
        @(negedge clk);
        clr_start = 1'b1; req_valid = 4'b0010;
        req_addr[1*AW +: AW] = 3'd6; req_data[1*WIDTH +: WIDTH] = 16'h1234;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL prio_ready got %b want 0000", req_ready);
        end
        @(negedge clk) clr_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if ({req_ready, rf_we, rf_write_reg} !== {4'b0000, 1'b1, 3'(i)}) begin
                errors++; $display("FAIL prio_clear%0d got ready=%b we=%b reg=%0d want 0000 1 %0d",
                                   i, req_ready, rf_we, rf_write_reg, i);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({clr_done, clr_busy, req_ready} !== {2'b10, 4'b0010}) begin
            errors++; $display("FAIL prio_after got done=%b busy=%b ready=%b want 1 0 0010", clr_done, clr_busy, req_ready);
        end
        @(negedge clk) req_valid = '0;
        #1;
        checks++;
        if ({rf_we, rf_write_reg, grant_id, rf_write_data} !== {1'b1, 3'd6, 2'd1, 16'h1234}) begin
            errors++; $display("FAIL prio_grant got we=%b reg=%0d gid=%0d data=%h want 1 6 1 1234",
                               rf_we, rf_write_reg, grant_id, rf_write_data);
        end
    endtask

    task automatic test_clr_restart();
        int wcnt = 0;
        int dcnt = 0;
        @(negedge clk) clr_start = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 14; n++) begin
            clr_start = (n == 3);
            #1;
            if (rf_we) begin
                checks++;
                if ({rf_write_reg, rf_write_data} !== {3'(wcnt), 16'h0000}) begin
                    errors++; $display("FAIL restart_write%0d got reg=%0d data=%h want %0d 0000",
                                       wcnt, rf_write_reg, rf_write_data, wcnt);
                end
                wcnt++;
            end
            if (clr_done) dcnt++;
            @(negedge clk);
        end
        clr_start = 1'b0;
        checks++;
        if (wcnt != 8) begin
            errors++; $display("FAIL restart_writes got %0d want 8", wcnt);
        end
        checks++;
        if (dcnt != 1) begin
            errors++; $display("FAIL restart_done got %0d want 1", dcnt);
        end
    endtask

    task automatic test_reset_mid_clear();
        int wcnt = 0;
        int dcnt = 0;
        req_valid = 4'b0001; req_addr[0 +: AW] = 3'd7; req_data[0 +: WIDTH] = 16'h5555;
        @(negedge clk) req_valid = '0;
        @(negedge clk) #1;
        checks++;
        if (mem[7] !== 16'h5555) begin
            errors++; $display("FAIL midrst_prep got %h want 5555", mem[7]);
        end
        clr_start = 1'b1;
        @(negedge clk) clr_start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1;
        checks++;
        if ({clr_busy, rf_write_reg} !== {1'b1, 3'd4}) begin
            errors++; $display("FAIL midrst_index got busy=%b reg=%0d want 1 4", clr_busy, rf_write_reg);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rf_we, clr_busy, clr_done, req_ready, rf_write_reg, rf_write_data, grant_id} !== '0) begin
            errors++; $display("FAIL midrst_outputs got we=%b busy=%b done=%b ready=%b reg=%0d data=%h gid=%0d want all 0",
                               rf_we, clr_busy, clr_done, req_ready, rf_write_reg, rf_write_data, grant_id);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) #1;
        checks++;
        if ({rf_we, clr_busy} !== 2'b00) begin
            errors++; $display("FAIL midrst_idle got we=%b busy=%b want 0 0", rf_we, clr_busy);
        end
        checks++;
        if ({mem[3], mem[7]} !== {16'h0000, 16'h5555}) begin
            errors++; $display("FAIL midrst_partial got mem3=%h mem7=%h want 0000 5555", mem[3], mem[7]);
        end
        @(negedge clk) clr_start = 1'b1;
        @(negedge clk) clr_start = 1'b0;
        for (int n = 0; n < 12; n++) begin
            #1;
            if (rf_we) begin
                checks++;
                if (rf_write_reg !== 3'(wcnt)) begin
                    errors++; $display("FAIL midrst_refill%0d got reg=%0d want %0d", wcnt, rf_write_reg, wcnt);
                end
                wcnt++;
            end
            if (clr_done) dcnt++;
            @(negedge clk);
        end
        checks++;
        if ({wcnt, dcnt} != {32'd8, 32'd1}) begin
            errors++; $display("FAIL midrst_refill_count got writes=%0d done=%0d want 8 1", wcnt, dcnt);
        end
        checks++;
        if (mem[7] !== 16'h0000) begin
            errors++; $display("FAIL midrst_refill_mem7 got %h want 0000", mem[7]);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_single();
        test_round_robin();
        test_clr_priority();
        test_clr_restart();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
